// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multi-channel scanning selector.
package mux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      WAIT  = 2'd2
   } scan_state_t;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_out_slice.sv
// Single-entry output register with a valid/ready handshake toward the consumer.
module mux_out_slice #(
   parameter int W    = 8,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [W-1:0]    load_data,
   input  logic [SELW-1:0] load_ch,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_ch,
   output logic            out_valid,
   output logic            slot_free
);

   // Handshake: a sample transfers on any cycle with out_valid & out_ready; while
   // out_valid is high and out_ready low, out_data/out_ch hold stable. The slot is
   // free (may be reloaded) when empty or being drained this cycle.
   logic [W-1:0]    data_q, data_d;
   logic [SELW-1:0] ch_q, ch_d;
   logic            valid_q, valid_d;

   assign slot_free = !valid_q || out_ready;

   always_comb begin
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      if (load && slot_free) begin
         data_d  = load_data;
         ch_d    = load_ch;
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/mux_scan_seq.sv
// NCH:1 channel selector with MANUAL select and SCAN round-robin sweep modes,
// feeding a registered valid/ready output slot.
module mux_scan_seq
   import mux_scan_pkg::*;
#(
   parameter  int W       = 8,
   parameter  int NCH     = 4,
   parameter  int DWELL_W = 8,
   localparam int SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH*W-1:0]   ch_data,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               start,
   output logic [W-1:0]       out_data,
   output logic [SELW-1:0]    out_ch,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic               sel_err,
   output scan_state_t        dbg_state
);

   localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
   localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

   scan_state_t        state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwl_q, dwl_d;
   logic [SELW-1:0]    ch_q, ch_d;

   logic               slot_free;
   logic               load;
   logic [SELW-1:0]    cap_idx;
   logic [W-1:0]       cap_data;
   logic               sel_ok;
   logic               sel_err_c;

   assign sel_ok   = ({1'b0, sel} < NCH_W);
   // cap_idx is only ever sel when sel_ok, or ch_q which never exceeds LAST_CH.
   assign cap_data = ch_data[32'(cap_idx)*W +: W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dwl_q   <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dwl_q   <= dwl_d;
         ch_q    <= ch_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dwl_d   = dwl_q;
      ch_d    = ch_q;
      case (state_q)
         IDLE: begin
            if (mode == MODE_SCAN && start) begin
               dwl_d   = dwell;
               cnt_d   = dwell;
               ch_d    = '0;
               state_d = DWELL;
            end
         end
         DWELL, WAIT: begin
            if (state_q == DWELL && cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_W'(1);
            end else if (slot_free) begin
               // Capture happens this cycle; step to the next channel or finish.
               if (ch_q == LAST_CH) begin
                  ch_d    = '0;
                  state_d = IDLE;
               end else begin
                  ch_d    = ch_q + SELW'(1);
                  cnt_d   = dwl_q;
                  state_d = DWELL;
               end
            end else begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      load      = 1'b0;
      cap_idx   = ch_q;
      sel_err_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (mode == MODE_MANUAL) begin
               if (sel_ok) begin
                  cap_idx = sel;
                  load    = slot_free;
               end else begin
                  sel_err_c = 1'b1;
               end
            end
         end
         DWELL:   load = (cnt_q == '0) && slot_free;
         WAIT:    load = slot_free;
         default: load = 1'b0;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign sel_err   = sel_err_c && rst_n;
   assign dbg_state = state_q;

   mux_out_slice #(
      .W    (W),
      .SELW (SELW)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (cap_data),
      .load_ch   (cap_idx),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .slot_free (slot_free)
   );

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq: manual vector table, random manual traffic
// against a reference model, and scoreboarded scan sweeps.
module tb_mux_scan_seq;
   import mux_scan_pkg::*;

   localparam int W    = 8;
   localparam int NCH  = 5;
   localparam int DW   = 8;
   localparam int SELW = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NCH*W-1:0]   ch_data;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [DW-1:0]      dwell;
   logic               start;
   logic [W-1:0]       out_data;
   logic [SELW-1:0]    out_ch;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic               sel_err;
   scan_state_t        dbg_state;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   logic [W+SELW-1:0] exp_q[$];

   mux_scan_seq #(.W(W), .NCH(NCH), .DWELL_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch_data   (ch_data),
      .mode      (mode),
      .sel       (sel),
      .dwell     (dwell),
      .start     (start),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .sel_err   (sel_err),
      .dbg_state (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [NCH*W-1:0] mk_chans(input logic [W-1:0] base);
      logic [NCH*W-1:0] v;
      for (int k = 0; k < NCH; k++) v[k*W +: W] = base + W'(k);
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; mode = 1'b1; sel = '0; start = 1'b0;
      out_ready = 1'b0; dwell = '0; ch_data = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One SCAN sweep. rmode: 0 ready high, 1 ready toggling, 2 ready random.
   task automatic run_scan(input int dw, input int rmode, input bit toggle);
      int t_start, got, budget;
      logic [W+SELW-1:0] e;
      exp_q.delete();
      for (int k = 0; k < NCH; k++) begin
         ch_data[k*W +: W] = W'($urandom);
         exp_q.push_back({SELW'(k), ch_data[k*W +: W]});
      end
      mode = 1'b1; start = 1'b1; dwell = DW'(dw); out_ready = 1'b0;
      @(negedge clk);
      t_start = cyc;
      start = 1'b0;
      got = 0; budget = 0;
      while (got < NCH && budget < 600) begin
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom);
         endcase
         if (toggle) begin
            if (busy) begin
               start = 1'($urandom); mode = 1'($urandom);
               sel = SELW'($urandom); dwell = DW'($urandom);
            end else begin
               start = 1'b0; mode = 1'b1;
            end
         end
         #1;
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check("scan_ch", 32'(out_ch), 32'(e[W+SELW-1:W]));
            check("scan_data", 32'(out_data), 32'(e[W-1:0]));
            check("scan_busy", 32'(busy), 32'(got != NCH-1));
            if (rmode == 0) check("scan_time", cyc, t_start + 1 + dw + got*(dw + 1));
            got++;
         end
         @(negedge clk);
         budget++;
      end
      if (got < NCH) check("scan_timeout", got, NCH);
      out_ready = 1'b1; mode = 1'b1; start = 1'b0;
      check("scan_drain_valid", 32'(out_valid), 0);
      check("scan_drain_busy", 32'(busy), 0);
   endtask

   typedef struct {
      logic [SELW-1:0] sel;
      logic            rdy;
      logic [W-1:0]    base;
      logic            exp_v;
      logic [W-1:0]    exp_d;
      logic [SELW-1:0] exp_c;
      logic            exp_err;
   } vec_t;

   vec_t vt[12];

   initial begin
      logic            mv;
      logic [W-1:0]    md;
      logic [SELW-1:0] mc;

      vt[0]  = '{3'd2, 1'b1, 8'hA3, 1'b1, 8'hA5, 3'd2, 1'b0};
      vt[1]  = '{3'd1, 1'b1, 8'h10, 1'b1, 8'h11, 3'd1, 1'b0};
      vt[2]  = '{3'd4, 1'b1, 8'h20, 1'b1, 8'h24, 3'd4, 1'b0};
      vt[3]  = '{3'd0, 1'b0, 8'h30, 1'b1, 8'h24, 3'd4, 1'b0};
      vt[4]  = '{3'd3, 1'b0, 8'h40, 1'b1, 8'h24, 3'd4, 1'b0};
      vt[5]  = '{3'd2, 1'b0, 8'h50, 1'b1, 8'h24, 3'd4, 1'b0};
      vt[6]  = '{3'd7, 1'b0, 8'h60, 1'b1, 8'h24, 3'd4, 1'b1};
      vt[7]  = '{3'd5, 1'b1, 8'h60, 1'b0, 8'h24, 3'd4, 1'b1};
      vt[8]  = '{3'd3, 1'b0, 8'h70, 1'b1, 8'h73, 3'd3, 1'b0};
      vt[9]  = '{3'd0, 1'b1, 8'h80, 1'b1, 8'h80, 3'd0, 1'b0};
      vt[10] = '{3'd6, 1'b0, 8'h90, 1'b1, 8'h80, 3'd0, 1'b1};
      vt[11] = '{3'd1, 1'b1, 8'h9F, 1'b1, 8'hA0, 3'd1, 1'b0};

      do_reset();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      check("rst_ch", 32'(out_ch), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_sel_err", 32'(sel_err), 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));

      // manual vector table
      mode = MODE_MANUAL;
      for (int i = 0; i < 12; i++) begin
         sel = vt[i].sel; out_ready = vt[i].rdy; ch_data = mk_chans(vt[i].base);
         #1;
         check($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'(vt[i].exp_err));
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_v));
         check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp_d));
         check($sformatf("vec%0d_ch", i), 32'(out_ch), 32'(vt[i].exp_c));
      end

      // random manual traffic against a reference model
      do_reset();
      mv = 1'b0; md = '0; mc = '0;
      mode = MODE_MANUAL;
      for (int i = 0; i < 150; i++) begin
         sel = SELW'($urandom_range(0, 7));
         out_ready = 1'($urandom);
         ch_data = {$urandom, $urandom};
         #1;
         check("rnd_sel_err", 32'(sel_err), 32'(int'(sel) >= NCH));
         if ((!mv || out_ready) && int'(sel) < NCH) begin
            mv = 1'b1; md = ch_data[int'(sel)*W +: W]; mc = sel;
         end else if (out_ready) begin
            mv = 1'b0;
         end
         @(negedge clk);
         check("rnd_valid", 32'(out_valid), 32'(mv));
         check("rnd_data", 32'(out_data), 32'(md));
         check("rnd_ch", 32'(out_ch), 32'(mc));
      end

      // scan sweeps
      do_reset();
      run_scan(3, 0, 1'b0);
      run_scan(0, 0, 1'b0);
      run_scan(0, 1, 1'b0);
      run_scan(2, 1, 1'b1);
      for (int i = 0; i < 4; i++) run_scan($urandom_range(0, 4), 2, 1'($urandom));

      // reset while a sweep is stalled in WAIT with a pending sample
      ch_data = mk_chans(8'h40);
      mode = MODE_SCAN; start = 1'b1; dwell = '0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("wait_state", 32'(dbg_state), 32'(WAIT));
      check("wait_valid", 32'(out_valid), 1);
      check("wait_data", 32'(out_data), 32'h40);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_data", 32'(out_data), 0);
      check("arst_ch", 32'(out_ch), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_scan(2, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
